// File: rtl/incubator_scheduler.sv
// Round-robin shared-ADC scheduler driving per-chamber hysteresis heater/cooler control.
// Optional two-sample averaging filter: define INCUBATOR_AVG_FILTER_EN.
module incubator_scheduler #(
  parameter  int unsigned NUM_CH     = 4,
  parameter  int unsigned SAMPLE_DIV = 16,
  parameter  int unsigned TIMEOUT    = 8,
  localparam int unsigned CHW        = $clog2(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  adc_req,
  output logic [CHW-1:0]        adc_ch,
  input  logic                  adc_ack,
  input  logic [7:0]            adc_data,
  output logic [NUM_CH-1:0]     heater,
  output logic [NUM_CH-1:0]     cooler,
  output logic [8*NUM_CH-1:0]   crs,
  output logic                  sample_valid,
  output logic [CHW-1:0]        sample_ch,
  output logic [NUM_CH-1:0]     timeout_err,
  input  logic                  err_clr
);

  localparam int unsigned DIVW = $clog2(SAMPLE_DIV + 1);
  localparam int unsigned WW   = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_UPDATE = 2'd2;
  localparam logic [1:0] S_NEXT   = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [DIVW-1:0]         div_q, div_d;
  logic [WW-1:0]           wcnt_q, wcnt_d;
  logic [CHW-1:0]          ptr_q, ptr_d;
  logic                    req_q, req_d;
  logic [7:0]              data_q, data_d;
  logic [NUM_CH-1:0]       heater_q, heater_d;
  logic [NUM_CH-1:0]       cooler_q, cooler_d;
  logic [NUM_CH-1:0]       terr_q, terr_d;
  logic [NUM_CH-1:0][7:0]  crs_q, crs_d;
  logic                    sv_q, sv_d;
  logic [CHW-1:0]          sch_q, sch_d;
  logic [7:0]              t_c;
  logic                    heat_c, cool_c;
`ifdef INCUBATOR_AVG_FILTER_EN
  logic [NUM_CH-1:0][7:0]  prev_q, prev_d;
  logic [NUM_CH-1:0]       seeded_q, seeded_d;
`endif

  // Effective temperature and hysteresis decisions for the chamber under service
  always_comb begin
`ifdef INCUBATOR_AVG_FILTER_EN
    t_c = seeded_q[ptr_q] ? 8'(({1'b0, prev_q[ptr_q]} + {1'b0, data_q}) >> 1) : data_q;
`else
    t_c = data_q;
`endif
    heat_c = heater_q[ptr_q];
    if (t_c < 8'd15)      heat_c = 1'b1;
    else if (t_c > 8'd30) heat_c = 1'b0;
    cool_c = cooler_q[ptr_q];
    if (t_c > 8'd35)      cool_c = 1'b1;
    else if (t_c < 8'd25) cool_c = 1'b0;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    wcnt_d   = wcnt_q;
    ptr_d    = ptr_q;
    req_d    = req_q;
    data_d   = data_q;
    heater_d = heater_q;
    cooler_d = cooler_q;
    crs_d    = crs_q;
    sv_d     = 1'b0;
    sch_d    = sch_q;
    terr_d   = err_clr ? '0 : terr_q;
`ifdef INCUBATOR_AVG_FILTER_EN
    prev_d   = prev_q;
    seeded_d = seeded_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (div_q == DIVW'(SAMPLE_DIV - 1)) begin
          state_d = S_REQ;
          req_d   = 1'b1;
          wcnt_d  = '0;
        end else begin
          div_d = div_q + DIVW'(1);
        end
      end
      S_REQ: begin
        if (adc_ack) begin
          data_d  = adc_data;
          req_d   = 1'b0;
          state_d = S_UPDATE;
        end else if (wcnt_q == WW'(TIMEOUT - 1)) begin
          // Timeout sets after err_clr so a coincident clear loses
          req_d            = 1'b0;
          state_d          = S_NEXT;
          terr_d[ptr_q]    = 1'b1;
          heater_d[ptr_q]  = 1'b0;
          cooler_d[ptr_q]  = 1'b0;
          crs_d[ptr_q]     = 8'd0;
`ifdef INCUBATOR_AVG_FILTER_EN
          seeded_d[ptr_q]  = 1'b0;
`endif
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      S_UPDATE: begin
        heater_d[ptr_q] = heat_c;
        cooler_d[ptr_q] = cool_c;
        if (!cool_c)            crs_d[ptr_q] = 8'd0;
        else if (t_c >= 8'd45)  crs_d[ptr_q] = 8'd8;
        else if (t_c >= 8'd40)  crs_d[ptr_q] = 8'd6;
        else                    crs_d[ptr_q] = 8'd4;
        sv_d    = 1'b1;
        sch_d   = ptr_q;
        state_d = S_NEXT;
`ifdef INCUBATOR_AVG_FILTER_EN
        prev_d[ptr_q]   = data_q;
        seeded_d[ptr_q] = 1'b1;
`endif
      end
      S_NEXT: begin
        ptr_d   = (ptr_q == CHW'(NUM_CH - 1)) ? '0 : ptr_q + CHW'(1);
        div_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      wcnt_q   <= '0;
      ptr_q    <= '0;
      req_q    <= 1'b0;
      data_q   <= '0;
      heater_q <= '0;
      cooler_q <= '0;
      crs_q    <= '0;
      sv_q     <= 1'b0;
      sch_q    <= '0;
      terr_q   <= '0;
`ifdef INCUBATOR_AVG_FILTER_EN
      prev_q   <= '0;
      seeded_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      wcnt_q   <= wcnt_d;
      ptr_q    <= ptr_d;
      req_q    <= req_d;
      data_q   <= data_d;
      heater_q <= heater_d;
      cooler_q <= cooler_d;
      crs_q    <= crs_d;
      sv_q     <= sv_d;
      sch_q    <= sch_d;
      terr_q   <= terr_d;
`ifdef INCUBATOR_AVG_FILTER_EN
      prev_q   <= prev_d;
      seeded_q <= seeded_d;
`endif
    end
  end

  assign adc_req      = req_q;
  assign adc_ch       = ptr_q;
  assign heater       = heater_q;
  assign cooler       = cooler_q;
  assign crs          = crs_q;
  assign sample_valid = sv_q;
  assign sample_ch    = sch_q;
  assign timeout_err  = terr_q;

endmodule
